pipelined_barrel_shifter: RTL

//  Parametrised, pipelined multi-function barrel shifter with valid/ready flow control.

---
 rtl/pipelined_barrel_shifter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined LSR/LSL/ASR/ROR barrel shifter on a 2**N-bit operand. Stage k applies the
// 2**k shift, and valid/ready handshaking lets the chain stall without losing ops.
module pipelined_barrel_shifter #(
  parameter int N = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [(2**N)-1:0]   a,
  input  logic [N-1:0]        amt,
  input  logic [1:0]          op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [(2**N)-1:0]   y,
  output logic                busy
);

  localparam int W = 2**N;

  localparam logic [1:0] OP_LSR = 2'b00;
  localparam logic [1:0] OP_LSL = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  // One stage's work: shift by 2**k when enabled. ASR fills from the carried operand sign.
  function automatic logic [W-1:0] shift_stage(input logic [W-1:0] d, input logic en,
                                               input int k, input logic [1:0] o,
                                               input logic sgn);
    logic [W-1:0] r;
    logic [W-1:0] fill;
    int           s;
    s    = 1 << k;
    fill = ~({W{1'b1}} >> s);
    if (!en) begin
      r = d;
    end else begin
      case (o)
        OP_LSR:  r = d >> s;
        OP_LSL:  r = d << s;
        OP_ASR:  r = (d >> s) | (sgn ? fill : {W{1'b0}});
        OP_ROR:  r = (d >> s) | (d << (W - s));
        default: r = d;
      endcase
    end
    return r;
  endfunction

  logic [N-1:0] vld_q, vld_d;
  logic [W-1:0] data_q [N];
  logic [W-1:0] data_d [N];
  logic [N-1:0] amt_q  [N];
  logic [N-1:0] amt_d  [N];
  logic [1:0]   op_q   [N];
  logic [1:0]   op_d   [N];
  logic         sgn_q  [N];
  logic         sgn_d  [N];
  logic [N-1:0] load_s;
  logic         unused_s;

  // A stage may load when some stage at or above it has a hole, or the output drains.
  for (genvar k = 0; k < N; k++) begin : g_load
    assign load_s[k] = ~(&vld_q[N-1:k]) | out_ready;
  end

  // Next-state for every stage: hold by default, otherwise take the shifted upstream op.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    amt_d  = amt_q;
    op_d   = op_q;
    sgn_d  = sgn_q;
    if (load_s[0]) begin
      vld_d[0] = in_valid;
      if (in_valid) begin
        data_d[0] = shift_stage(a, amt[0], 0, op, a[W-1]);
        amt_d[0]  = amt;
        op_d[0]   = op;
        sgn_d[0]  = a[W-1];
      end else begin
        data_d[0] = data_q[0];
      end
    end else begin
      vld_d[0] = vld_q[0];
    end
    for (int k = 1; k < N; k++) begin
      if (load_s[k]) begin
        vld_d[k] = vld_q[k-1];
        if (vld_q[k-1]) begin
          data_d[k] = shift_stage(data_q[k-1], amt_q[k-1][k], k, op_q[k-1], sgn_q[k-1]);
          amt_d[k]  = amt_q[k-1];
          op_d[k]   = op_q[k-1];
          sgn_d[k]  = sgn_q[k-1];
        end else begin
          data_d[k] = data_q[k];
        end
      end else begin
        vld_d[k] = vld_q[k];
      end
    end
  end

  // Stage registers; reset drops every in-flight op and clears the data path.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= {N{1'b0}};
      for (int k = 0; k < N; k++) begin
        data_q[k] <= {W{1'b0}};
        amt_q[k]  <= {N{1'b0}};
        op_q[k]   <= 2'b00;
        sgn_q[k]  <= 1'b0;
      end
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      amt_q  <= amt_d;
      op_q   <= op_d;
      sgn_q  <= sgn_d;
    end
  end

  assign in_ready  = load_s[0];
  assign out_valid = vld_q[N-1];
  assign y         = data_q[N-1];
  assign busy      = |vld_q;

  // The final stage's control fields have no consumer downstream.
  assign unused_s = ^{amt_q[N-1], op_q[N-1], sgn_q[N-1]};

endmodule
